pwm_bank: RTL and testbench

PWM_BANK -- requirements
Module: pwm_bank

---
 rtl/pwm_bank_if.sv | 12 +
 rtl/pwm_bank.sv | 142 ++++++++++++++
 tb/tb_pwm_bank.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_bank_if.sv
// Register bus for pwm_bank: word address, single-cycle read/write strobes,
// registered read data.
interface pwm_bank_if;
  logic [7:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;

  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/pwm_bank.sv
// Bank of NUM_CH PWM channels sharing one period counter, with shadowed PERIOD/DUTY
// registers. Define PWM_BANK_IRQ_EN to add the wrap interrupt (irq port, CTRL bit2).
module pwm_bank #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  pwm_bank_if.slave         bus,
  output logic [NUM_CH-1:0] pwm_out
`ifdef PWM_BANK_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [7:0] ADDR_CTRL   = 8'd0;
  localparam logic [7:0] ADDR_PERIOD = 8'd1;
  localparam logic [7:0] ADDR_STATUS = 8'd2;
  localparam logic [7:0] ADDR_DUTY0  = 8'd4;

  logic             ctrl_enable;
  logic             ctrl_invert;
  logic             ctrl_irq_en;
  logic             irq_pending;
  logic [CNT_W-1:0] period_shadow;
  logic [CNT_W-1:0] period_active;
  logic [CNT_W-1:0] duty_shadow [NUM_CH];
  logic [CNT_W-1:0] duty_active [NUM_CH];
  logic [CNT_W-1:0] counter;
  logic [15:0]      wrap_cnt;
  logic [31:0]      rdata_q;
  logic [31:0]      rdata_next;

  logic             wrap;
  logic             load_active;
  logic             ctrl_wr;
  logic             status_wr;
  logic             period_wr;
  logic [NUM_CH-1:0] duty_wr;
  logic [CNT_W-1:0] wdata_cnt;
  logic [CNT_W-1:0] period_next;
  logic [CNT_W-1:0] duty_next [NUM_CH];
  logic             unused_wdata;

  assign unused_wdata = ^bus.writedata;
  assign bus.readdata = rdata_q;

  // A write coinciding with a load must reach the active copy, so the active
  // registers load from the post-write shadow value rather than the old one.
  always_comb begin
    wdata_cnt   = bus.writedata[CNT_W-1:0];
    ctrl_wr     = bus.write && (bus.address == ADDR_CTRL);
    status_wr   = bus.write && (bus.address == ADDR_STATUS);
    period_wr   = bus.write && (bus.address == ADDR_PERIOD);
    wrap        = ctrl_enable && (counter == period_active);
    load_active = !ctrl_enable || wrap;
    period_next = period_wr ? wdata_cnt : period_shadow;
    duty_wr     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      duty_wr[i]   = bus.write && (bus.address == 8'(ADDR_DUTY0 + i));
      duty_next[i] = duty_wr[i] ? wdata_cnt : duty_shadow[i];
    end
  end

  always_comb begin
    rdata_next = '0;
    if (bus.read) begin
      case (bus.address)
        ADDR_CTRL:   rdata_next = {29'd0, ctrl_irq_en, ctrl_invert, ctrl_enable};
        ADDR_PERIOD: rdata_next = 32'(period_shadow);
        ADDR_STATUS: rdata_next = {wrap_cnt, 14'd0, irq_pending, ctrl_enable};
        default: begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.address == 8'(ADDR_DUTY0 + i)) rdata_next = 32'(duty_shadow[i]);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_enable   <= 1'b0;
      ctrl_invert   <= 1'b0;
      period_shadow <= '0;
      period_active <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        duty_shadow[i] <= '0;
        duty_active[i] <= '0;
      end
      counter  <= '0;
      wrap_cnt <= '0;
      pwm_out  <= '0;
      rdata_q  <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_enable <= bus.writedata[0];
        ctrl_invert <= bus.writedata[1];
      end
      period_shadow <= period_next;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        duty_shadow[i] <= duty_next[i];
      end
      if (load_active) begin
        period_active <= period_next;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          duty_active[i] <= duty_next[i];
        end
      end
      if (!ctrl_enable || wrap) counter <= '0;
      else                      counter <= counter + CNT_W'(1);
      if (wrap) wrap_cnt <= wrap_cnt + 16'd1;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= ctrl_enable && ((counter < duty_active[i]) ^ ctrl_invert);
      end
      rdata_q <= rdata_next;
    end
  end

`ifdef PWM_BANK_IRQ_EN
  // A wrap in the same cycle as a STATUS write wins so no wrap event is lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_irq_en <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl_irq_en <= bus.writedata[2];
      if (wrap && ctrl_irq_en) irq_pending <= 1'b1;
      else if (status_wr)      irq_pending <= 1'b0;
    end
  end

  assign irq = irq_pending;
`else
  logic unused_status_wr;
  assign unused_status_wr = status_wr;
  assign ctrl_irq_en      = 1'b0;
  assign irq_pending      = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_bank.sv
// Directed self-checking bench for pwm_bank (NUM_CH=8, CNT_W=16); the irq
// steps are built only when PWM_BANK_IRQ_EN is defined.
module tb_pwm_bank;

  logic       clock;
  logic       reset;
  logic [7:0] pwm_out;
`ifdef PWM_BANK_IRQ_EN
  logic       irq;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] d;
  // Bit k = expected pwm_out[0] on the k-th sampled cycle.
  logic [19:0] pat29 = 20'b0000000111_0000000111;
  logic [17:0] pat30 = 18'b000_1111111_0000000_1;

  pwm_bank_if bus ();

  pwm_bank #(.NUM_CH(8), .CNT_W(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .pwm_out (pwm_out)
`ifdef PWM_BANK_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic wr(input logic [7:0] a, input logic [31:0] wd);
    bus.address   = a;
    bus.writedata = wd;
    bus.write     = 1'b1;
    @(negedge clock);
    bus.write     = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] rdv);
    bus.address = a;
    bus.read    = 1'b1;
    @(negedge clock);
    bus.read    = 1'b0;
    rdv         = bus.readdata;
  endtask

  task automatic rw(input logic [7:0] a, input logic [31:0] wd, output logic [31:0] rdv);
    bus.address   = a;
    bus.writedata = wd;
    bus.write     = 1'b1;
    bus.read      = 1'b1;
    @(negedge clock);
    bus.write     = 1'b0;
    bus.read      = 1'b0;
    rdv           = bus.readdata;
  endtask

  initial begin
    reset         = 1'b0;
    bus.address   = '0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.writedata = '0;

    repeat (2) @(negedge clock);
    check("rst_pwm", 32'(pwm_out), 32'h0);
    check("rst_rdata", bus.readdata, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    rd(8'd0, d); check("rst_ctrl", d, 32'h0);
    rd(8'd1, d); check("rst_period", d, 32'h0);
    rd(8'd2, d); check("rst_status", d, 32'h0);

    wr(8'd3, 32'hFFFF_FFFF);
    wr(8'd200, 32'h1234_5678);
    rd(8'd3, d);   check("rd_reserved", d, 32'h0);
    rd(8'd200, d); check("rd_unmapped", d, 32'h0);

    wr(8'd1, 32'hABCD_0009);
    rd(8'd1, d); check("period_trunc", d, 32'h9);
    @(negedge clock);
    check("rdata_idle", bus.readdata, 32'h0);

    // PERIOD=9, DUTY0=3: 3 high, 7 low, repeating
    wr(8'd4, 32'd3);
    wr(8'd0, 32'h1);
    for (int k = 0; k < 20; k++) begin
      @(posedge clock); #1;
      check($sformatf("duty3_c%0d", k), 32'(pwm_out[0]), 32'(pat29[k]));
    end

    // DUTY0=7 mid-period: shadow readback now, active after the wrap
    @(negedge clock);
    wr(8'd4, 32'd7);
    rd(8'd4, d); check("duty0_shadow", d, 32'd7);
    for (int k = 0; k < 18; k++) begin
      @(posedge clock); #1;
      check($sformatf("duty7_c%0d", k), 32'(pwm_out[0]), 32'(pat30[k]));
    end

    // disable with invert set: outputs low, four wraps so far held
    @(negedge clock);
    wr(8'd0, 32'h2);
    repeat (2) @(negedge clock);
    check("dis_inv_pwm", 32'(pwm_out), 32'h0);
    rd(8'd2, d); check("status_4wraps", d, 32'h0004_0000);

    // DUTY1=0 / DUTY2=20 inverted
    wr(8'd5, 32'd0);
    wr(8'd6, 32'd20);
    wr(8'd0, 32'h3);
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      check($sformatf("inv_edges_c%0d", k), 32'(pwm_out[2:1]), 32'h1);
    end

    // asynchronous reset between clock edges
    @(negedge clock);
    rd(8'd1, d); check("pre_rst_period", d, 32'd9);
    #1 reset = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm_out), 32'h0);
    check("async_rst_rdata", bus.readdata, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    rd(8'd0, d); check("post_rst_ctrl", d, 32'h0);
    rd(8'd1, d); check("post_rst_period", d, 32'h0);
    rd(8'd4, d); check("post_rst_duty0", d, 32'h0);
    rd(8'd6, d); check("post_rst_duty2", d, 32'h0);
    repeat (5) @(negedge clock);
    check("post_rst_idle", 32'(pwm_out), 32'h0);

    // three full periods of PERIOD=4, then disable
    wr(8'd1, 32'd4);
    wr(8'd4, 32'd2);
    wr(8'd0, 32'h1);
    repeat (15) @(posedge clock);
    @(negedge clock);
    wr(8'd0, 32'h0);
    rd(8'd2, d); check("status_3wraps", d, 32'h0003_0000);
    check("dis_pwm", 32'(pwm_out), 32'h0);
    repeat (10) @(negedge clock);
    rd(8'd2, d); check("wraps_hold", d, 32'h0003_0000);

    // PERIOD=0: counter parked at 0, every enabled cycle wraps
    wr(8'd1, 32'd0);
    wr(8'd4, 32'd1);
    wr(8'd0, 32'h1);
    repeat (5) @(posedge clock);
    #1 check("p0_pwm", 32'(pwm_out[0]), 32'h1);
    @(negedge clock);
    wr(8'd0, 32'h0);
    rd(8'd2, d); check("p0_wraps", d, 32'h0009_0000);

    // same-cycle write and read returns the old value
    rw(8'd4, 32'd5, d); check("rw_old", d, 32'd1);
    rd(8'd4, d);        check("rw_new", d, 32'd5);

    // write landing on a wrap loads the new duty
    wr(8'd0, 32'h1);
    @(posedge clock); #1 check("wrapwr_before", 32'(pwm_out[0]), 32'h1);
    @(negedge clock);
    wr(8'd4, 32'd0);
    @(posedge clock); #1 check("wrapwr_after", 32'(pwm_out[0]), 32'h0);
    @(negedge clock);
    wr(8'd0, 32'h0);

`ifdef PWM_BANK_IRQ_EN
    wr(8'd1, 32'd4);
    wr(8'd0, 32'h5);
    repeat (4) @(negedge clock);
    check("irq_pre_wrap", 32'(irq), 32'h0);
    @(negedge clock);
    check("irq_wrap1", 32'(irq), 32'h1);
    rd(8'd2, d); check("status_pending", 32'(d[1:0]), 32'h3);
    check("irq_held", 32'(irq), 32'h1);
    wr(8'd2, 32'h0);
    check("irq_cleared", 32'(irq), 32'h0);
    repeat (2) @(negedge clock);
    check("irq_pre_wrap2", 32'(irq), 32'h0);
    @(negedge clock);
    check("irq_wrap2", 32'(irq), 32'h1);
    wr(8'd0, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
